mem_port_arbiter: RTL

Shares one single-ported unified memory between the pipelined MIPS fetch stage and the memory stage. Two requesters are served: instruction fetch (I) and data access (D). The block grants one transaction at a time and sequences the memory handshake. It returns per-requester completion pulses, which the hazard logic uses to stall F or M.

---
 rtl/mem_port_arbiter_pkg.sv | 22 ++
 rtl/mem_port_arbiter_arb_select.sv | 30 +++
 rtl/mem_port_arbiter.sv | 146 ++++++++++++++
 3 files changed

// File: rtl/mem_port_arbiter_pkg.sv
// Shared types for the unified-memory port arbiter.
//   arbState_t : arbiter FSM states
//   gnt_t      : grant decision from arb_select
//   MAX_I_WAIT_DEF : default number of D grants tolerated while I waits
package mem_arb_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    BUSY_I = 2'd1,
    BUSY_D = 2'd2,
    DONE   = 2'd3
  } arbState_t;

  typedef enum logic [1:0] {
    GNT_NONE = 2'd0,
    GNT_I    = 2'd1,
    GNT_D    = 2'd2
  } gnt_t;

  localparam int MAX_I_WAIT_DEF = 4;

endpackage

// File: rtl/mem_port_arbiter_arb_select.sv
// Combinational grant selection between fetch (I) and data (D) requesters.
// D has priority unless I has already waited through MAX_I_WAIT D grants.
// Ports:
//   iReq, dReq : pending requests
//   waitCnt    : consecutive D grants made while I was pending
//   grant      : gnt_t encoding (GNT_NONE / GNT_I / GNT_D)
module arb_select
  import mem_arb_pkg::*;
#(
  parameter int MAX_I_WAIT = MAX_I_WAIT_DEF,
  parameter int CW         = 3
) (
  input  logic          iReq,
  input  logic          dReq,
  input  logic [CW-1:0] waitCnt,
  output logic [1:0]    grant
);

  localparam logic [CW-1:0] MAXW = CW'(MAX_I_WAIT);

  always_comb begin
    grant = GNT_NONE;
    if (dReq && (!iReq || (waitCnt < MAXW))) begin
      grant = GNT_D;
    end else if (iReq) begin
      grant = GNT_I;
    end
  end

endmodule

// File: rtl/mem_port_arbiter.sv
// Arbitrates one single-ported memory between instruction fetch (I) and
// data access (D). One transaction at a time: IDLE -> BUSY_x -> DONE -> IDLE.
// Ports:
//   clk, reset            : clock, asynchronous active-high reset
//   i_req/i_addr          : fetch request, held until i_done
//   i_rdata/i_done        : fetched word (held) and one-cycle completion
//   d_req/d_we/d_addr/d_wdata : data request, held until d_done
//   d_rdata/d_done        : load data (updated on loads only) and completion
//   m_req/m_we/m_addr/m_wdata : memory request side, stable through BUSY
//   m_rdata/m_ack         : memory response, m_ack ends the transaction
module mem_port_arbiter
  import mem_arb_pkg::*;
#(
  parameter int MAX_I_WAIT = MAX_I_WAIT_DEF,
  parameter int AW         = 32,
  parameter int DW         = 32
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          i_req,
  input  logic [AW-1:0] i_addr,
  output logic [DW-1:0] i_rdata,
  output logic          i_done,
  input  logic          d_req,
  input  logic          d_we,
  input  logic [AW-1:0] d_addr,
  input  logic [DW-1:0] d_wdata,
  output logic [DW-1:0] d_rdata,
  output logic          d_done,
  output logic          m_req,
  output logic          m_we,
  output logic [AW-1:0] m_addr,
  output logic [DW-1:0] m_wdata,
  input  logic [DW-1:0] m_rdata,
  input  logic          m_ack
);

  localparam int CW = (MAX_I_WAIT < 1) ? 1 : $clog2(MAX_I_WAIT + 1);
  localparam logic [CW-1:0] MAXW = CW'(MAX_I_WAIT);

  arbState_t     state, stateNext;
  logic [CW-1:0] waitCnt;
  logic [1:0]    grantBits;
  gnt_t          grant;

  arb_select #(
    .MAX_I_WAIT(MAX_I_WAIT),
    .CW        (CW)
  ) uSelect (
    .iReq   (i_req),
    .dReq   (d_req),
    .waitCnt(waitCnt),
    .grant  (grantBits)
  );

  assign grant = gnt_t'(grantBits);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state <= IDLE;
    end else begin
      state <= stateNext;
    end
  end

  // m_req decodes directly from state so it drops the instant reset hits.
  always_comb begin
    stateNext = state;
    m_req     = 1'b0;
    unique case (state)
      IDLE: begin
        if (grant == GNT_D) begin
          stateNext = BUSY_D;
        end else if (grant == GNT_I) begin
          stateNext = BUSY_I;
        end
      end
      BUSY_I, BUSY_D: begin
        m_req = 1'b1;
        if (m_ack) begin
          stateNext = DONE;
        end
      end
      DONE: begin
        stateNext = IDLE;
      end
      default: begin
        stateNext = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      waitCnt <= '0;
      m_we    <= 1'b0;
      m_addr  <= '0;
      m_wdata <= '0;
      i_rdata <= '0;
      d_rdata <= '0;
      i_done  <= 1'b0;
      d_done  <= 1'b0;
    end else begin
      i_done <= 1'b0;
      d_done <= 1'b0;
      unique case (state)
        IDLE: begin
          if (grant == GNT_I) begin
            m_addr  <= i_addr;
            m_we    <= 1'b0;
            m_wdata <= '0;
            waitCnt <= '0;
          end else if (grant == GNT_D) begin
            m_addr  <= d_addr;
            m_we    <= d_we;
            m_wdata <= d_wdata;
            if (!i_req) begin
              waitCnt <= '0;
            end else if (waitCnt != MAXW) begin
              waitCnt <= waitCnt + 1'b1;
            end
          end else if (!i_req) begin
            waitCnt <= '0;
          end
        end
        BUSY_I: begin
          if (m_ack) begin
            i_rdata <= m_rdata;
            i_done  <= 1'b1;
          end
        end
        BUSY_D: begin
          if (m_ack) begin
            d_done <= 1'b1;
            if (!m_we) begin
              d_rdata <= m_rdata;
            end
          end
        end
        default: begin
        end
      endcase
    end
  end

endmodule
